// File: rtl/light_switch_pkg.sv
// Shared defaults and helpers for the push-button light toggle controller.
package light_switch_pkg;

  localparam int   SYNC_STAGES_DEF     = 2;
  localparam int   DEBOUNCE_CYCLES_DEF = 1;
  localparam logic LIGHT_RESET_DEF     = 1'b0;

  // Counter width able to hold 0..n, never narrower than one bit.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Synchronizes a raw button level and accepts a new level only after it persists.
// dout is the accepted level as it will be after the coming edge, so a consumer can act on that same edge.
module button_debouncer
  import light_switch_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam int             CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_p;
  logic                   btn_s;
  logic                   btn_db;
  logic                   btn_db_nxt;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_nxt;

  // Synchronizer stage boundary: only this chain touches the raw input.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_p <= '0;
    end else begin
      sync_p <= {sync_p[SYNC_STAGES-2:0], din};
    end
  end

  assign btn_s = sync_p[SYNC_STAGES-1];

  always_comb begin
    btn_db_nxt = btn_db;
    cnt_nxt    = cnt;
    if (btn_s == btn_db) begin
      cnt_nxt = '0;
    end else if (cnt == CNT_LAST) begin
      btn_db_nxt = btn_s;
      cnt_nxt    = '0;
    end else begin
      cnt_nxt = cnt + CNT_W'(1);
    end
  end

  // Debounce stage boundary.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_db <= 1'b0;
      cnt    <= '0;
    end else begin
      btn_db <= btn_db_nxt;
      cnt    <= cnt_nxt;
    end
  end

  assign dout = btn_db_nxt;

endmodule

// File: rtl/light_switch.sv
// Push-button toggle: each accepted press flips the lamp; releases are ignored.
module light_switch
  import light_switch_pkg::*;
#(
  parameter int   SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter logic LIGHT_RESET     = LIGHT_RESET_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic button,
  output logic light
);

  logic db_nxt;
  logic db_p1;
  logic press;

  button_debouncer #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk  (clk),
    .reset(reset),
    .din  (button),
    .dout (db_nxt)
  );

  // db_p1 mirrors the debouncer's accepted level, so this is its 0->1 acceptance.
  assign press = db_nxt & ~db_p1;

  // Toggle stage boundary.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db_p1 <= 1'b0;
      light <= LIGHT_RESET;
    end else begin
      db_p1 <= db_nxt;
      if (press) begin
        light <= ~light;
      end
    end
  end

endmodule

// File: tb/tb_light_switch.sv
// Randomized scoreboard bench for light_switch at DEBOUNCE_CYCLES=1 and DEBOUNCE_CYCLES=4.
module tb_light_switch;

  localparam int   SYNC = 2;
  localparam logic LR   = 1'b0;
  localparam int   HMAX = 8192;

  logic clk    = 1'b0;
  logic reset  = 1'b0;
  logic button = 1'b0;
  logic light0;
  logic light1;

  int total = 0;
  int bad   = 0;

  int dbc[2] = '{1, 4};
  bit hist[2][HMAX];
  int hcnt[2];
  bit acc[2];
  bit lt[2];
  bit q0[$];
  bit q1[$];

  always #10 clk = ~clk;

  light_switch dut0 (
    .clk   (clk),
    .reset (reset),
    .button(button),
    .light (light0)
  );

  light_switch #(.DEBOUNCE_CYCLES(4)) dut1 (
    .clk   (clk),
    .reset (reset),
    .button(button),
    .light (light1)
  );

  task automatic chk(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: light=%b expected=%b", name, $time, act, exp);
    end
  endtask

  // Synchronized level seen at edge k: the button sampled SYNC edges earlier.
  function automatic bit synced(input int i, input int k);
    if (k - SYNC >= 0) return hist[i][k - SYNC];
    return 1'b0;
  endfunction

  // A new level is accepted once the synchronized level has differed from the
  // accepted level on the last dbc edges in a row; only an accepted press flips.
  task automatic model_step(input int i);
    int k;
    bit ok;
    if (!reset) begin
      hcnt[i] = 0;
      acc[i]  = 1'b0;
      lt[i]   = LR;
    end else begin
      k = hcnt[i];
      if (k < HMAX) begin
        hist[i][k] = button;
        hcnt[i]    = k + 1;
      end
      ok = 1'b1;
      for (int j = 0; j < dbc[i]; j++) begin
        if (k - j < 0) ok = 1'b0;
        else if (synced(i, k - j) == acc[i]) ok = 1'b0;
      end
      if (ok) begin
        acc[i] = ~acc[i];
        if (acc[i]) lt[i] = ~lt[i];
      end
    end
    if (i == 0) q0.push_back(lt[i]);
    else        q1.push_back(lt[i]);
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  initial begin
    bit e;
    forever begin
      @(posedge clk);
      #2;
      if (q0.size() == 0) begin
        total++; bad++;
        $display("FAIL sb0_empty at %0t: light=%b expected=none", $time, light0);
      end else begin
        e = q0.pop_front();
        chk("light_db1", light0, e);
      end
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL sb1_empty at %0t: light=%b expected=none", $time, light1);
      end else begin
        e = q1.pop_front();
        chk("light_db4", light1, e);
      end
    end
  end

  task automatic drive(input bit v, input int n);
    repeat (n) begin
      @(negedge clk);
      button = v;
    end
  endtask

  task automatic async_reset(input int hold);
    @(negedge clk);
    #3 reset = 1'b0;
    #1;
    chk("async_rst_db1", light0, LR);
    chk("async_rst_db4", light1, LR);
    repeat (hold) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int v, n;
    reset  = 1'b0;
    button = 1'b0;
    #1;
    chk("rst_t0_db1", light0, LR);
    chk("rst_t0_db4", light1, LR);
    drive(0, 2);
    @(negedge clk);
    reset = 1'b1;
    drive(0, 2);

    // single press, second press, long hold
    drive(1, 1); drive(0, 5);
    drive(1, 1); drive(0, 2); drive(0, 3);
    drive(1, 4); drive(0, 6);

    // async reset with light on, released with button low
    async_reset(2);
    drive(0, 3);

    // short / exact pulses and a low glitch inside a press
    drive(1, 3); drive(0, 8);
    drive(1, 4); drive(0, 8);
    drive(1, 2); drive(0, 1); drive(1, 3); drive(0, 8);
    drive(1, 2); drive(0, 1); drive(1, 5); drive(0, 8);

    // reset mid-press, button still held at release
    drive(1, 3);
    async_reset(2);
    drive(1, 6); drive(0, 8);

    repeat (150) begin
      v = $urandom_range(0, 1);
      n = $urandom_range(1, 8);
      drive(v[0], n);
      if ($urandom_range(0, 29) == 0) async_reset($urandom_range(1, 3));
    end

    drive(0, 4);
    @(posedge clk);
    #5;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
